// File: rtl/softmax_in_packer_pkg.sv
// rtl/softmax_in_packer_pkg.sv - shared softmax FP16 types and helpers.
package softmax_in_packer_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t      FP16_NEG_INF = 16'hFC00;
  localparam logic [1:0] CNT_FULL     = 2'd2;

  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/softmax_in_packer_row_buf.sv
// rtl/softmax_in_packer_row_buf.sv - one N-lane row buffer with beat write and pad fill.
// Pad fill and the latched row length exist only with SOFTMAX_PACK_PAD_EN.
module softmax_row_buf
  import softmax_in_packer_pkg::*;
#(
  parameter int N  = 64,
  parameter int W  = 4,
  parameter int IW = $clog2(N / W),
  parameter int LW = $clog2(N) + 1
) (
  input  logic            clk,
`ifdef SOFTMAX_PACK_PAD_EN
  input  logic            rst_n,
  input  logic [W-1:0]    i_keep,
  input  logic            i_pad,
  input  logic            i_close,
  input  logic [LW-1:0]   i_len,
`endif
  input  logic            i_we,
  input  logic [IW-1:0]   i_beat_idx,
  input  logic [W*16-1:0] i_data,
  output logic [N*16-1:0] o_data,
  output logic [LW-1:0]   o_len
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int B = i / W;
    localparam int K = i % W;
    fp16_t r_lane;
    logic  w_hit;
    assign w_hit = i_we && (i_beat_idx == IW'(B));
`ifdef SOFTMAX_PACK_PAD_EN
    // A short row closes early: lanes of later beats are filled with -inf.
    logic w_fill;
    assign w_fill = i_we && i_pad && (i_beat_idx < IW'(B));
    always_ff @(posedge clk) begin
      if (w_hit) r_lane <= (i_pad && !i_keep[K]) ? FP16_NEG_INF : i_data[K*16 +: 16];
      else if (w_fill) r_lane <= FP16_NEG_INF;
    end
`else
    always_ff @(posedge clk) begin
      if (w_hit) r_lane <= i_data[K*16 +: 16];
    end
`endif
    assign o_data[i*16 +: 16] = r_lane;
  end

`ifdef SOFTMAX_PACK_PAD_EN
  logic [LW-1:0] r_len;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_len <= '0;
    else if (i_we && i_close) r_len <= i_len;
  end
  assign o_len = r_len;
`else
  assign o_len = LW'(N);
`endif

endmodule

// File: rtl/softmax_in_packer.sv
// rtl/softmax_in_packer.sv - packs W-lane FP16 beats into N-lane ping-pong rows for softmax.
// Define SOFTMAX_PACK_PAD_EN for short rows closed by s_last with s_keep padding.
module softmax_in_packer
  import softmax_in_packer_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W*16-1:0]        s_data,
  input  logic [W-1:0]           s_keep,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [N*16-1:0]        vec_out,
  output logic [$clog2(N):0]     vec_len,
  output logic                   vec_valid,
  input  logic                   vec_ready
);

  localparam int NB = N / W;
  localparam int IW = $clog2(NB);
  localparam int LW = $clog2(N) + 1;

  if ((N % W) != 0 || (N / W) < 2) begin : g_cfg_err
    $error("softmax_in_packer: N must be a multiple of W with N/W >= 2");
  end

  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_cnt;
  logic [IW-1:0] r_idx;

  logic          w_accept;
  logic          w_pop;
  logic          w_row_end;
  logic          w_close;

  assign s_ready   = (r_cnt < CNT_FULL);
  assign vec_valid = (r_cnt != 2'd0);
  assign w_accept  = s_valid && s_ready;
  assign w_pop     = vec_valid && vec_ready;
  assign w_row_end = (r_idx == IW'(NB - 1));

`ifdef SOFTMAX_PACK_PAD_EN
  logic [W-1:0]  w_keep;
  logic [LW-1:0] w_len;
  // Non-last beats count as fully kept, so a row ending at N/W beats latches N.
  assign w_keep  = s_last ? s_keep : '1;
  assign w_len   = LW'(32'(r_idx) * 32'(W) + popcount32(32'(w_keep)));
  assign w_close = w_accept && (w_row_end || s_last);
`else
  logic w_unused_pad;
  assign w_unused_pad = ^{s_last, s_keep};
  assign w_close      = w_accept && w_row_end;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
      r_idx <= '0;
    end else begin
      if (w_accept) r_idx <= w_close ? '0 : r_idx + IW'(1);
      if (w_close)  r_wp  <= ~r_wp;
      if (w_pop)    r_rp  <= ~r_rp;
      case ({w_close, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  logic [N*16-1:0] w_buf0_data;
  logic [N*16-1:0] w_buf1_data;
  logic [LW-1:0]   w_buf0_len;
  logic [LW-1:0]   w_buf1_len;

  softmax_row_buf #(.N(N), .W(W), .IW(IW), .LW(LW)) u_buf0 (
    .clk        (clk),
`ifdef SOFTMAX_PACK_PAD_EN
    .rst_n      (rst_n),
    .i_keep     (s_keep),
    .i_pad      (s_last),
    .i_close    (w_close),
    .i_len      (w_len),
`endif
    .i_we       (w_accept && !r_wp),
    .i_beat_idx (r_idx),
    .i_data     (s_data),
    .o_data     (w_buf0_data),
    .o_len      (w_buf0_len)
  );

  softmax_row_buf #(.N(N), .W(W), .IW(IW), .LW(LW)) u_buf1 (
    .clk        (clk),
`ifdef SOFTMAX_PACK_PAD_EN
    .rst_n      (rst_n),
    .i_keep     (s_keep),
    .i_pad      (s_last),
    .i_close    (w_close),
    .i_len      (w_len),
`endif
    .i_we       (w_accept && r_wp),
    .i_beat_idx (r_idx),
    .i_data     (s_data),
    .o_data     (w_buf1_data),
    .o_len      (w_buf1_len)
  );

  assign vec_out = r_rp ? w_buf1_data : w_buf0_data;
  assign vec_len = r_rp ? w_buf1_len  : w_buf0_len;

endmodule

// File: tb/tb_softmax_in_packer.sv
// tb/tb_softmax_in_packer.sv - self-checking bench for softmax_in_packer (N=64, W=4).
module tb_softmax_in_packer;
  import softmax_in_packer_pkg::*;

  localparam int N  = 64;
  localparam int W  = 4;
  localparam int NB = N / W;
`ifdef SOFTMAX_PACK_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W*16-1:0] s_data = '0;
  logic [W-1:0]    s_keep = '0;
  logic            s_last = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [N*16-1:0] vec_out;
  logic [6:0]      vec_len;
  logic            vec_valid;
  logic            vec_ready = 1'b1;

  always #5 clk = ~clk;

  softmax_in_packer #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .vec_out(vec_out), .vec_len(vec_len),
    .vec_valid(vec_valid), .vec_ready(vec_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [N*16-1:0] act, input logic [N*16-1:0] exp);
    int lane;
    checks++;
    if (act !== exp) begin
      failures++;
      lane = 0;
      for (int i = N - 1; i >= 0; i--) if (act[i*16 +: 16] !== exp[i*16 +: 16]) lane = i;
      $display("FAIL %s lane=%0d actual=%h required=%h", name, lane, act[lane*16 +: 16], exp[lane*16 +: 16]);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout actual=expired required=event", name);
  endtask

  // Reference model: rows as lists of lanes, output FIFO of at most two rows.
  typedef struct {
    logic [N*16-1:0] data;
    int              len;
  } row_t;

  row_t  m_q[$];
  fp16_t m_cur[$];
  int    m_real = 0;
  int    m_beats = 0;
  row_t  m_r;
  bit    m_acc, m_pop, m_lastb;
  int    d_pops = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cur.delete();
      m_real  = 0;
      m_beats = 0;
    end else begin
      m_acc = s_valid && (m_q.size() < 2);
      m_pop = vec_ready && (m_q.size() > 0);
      if (m_pop) begin
        void'(m_q.pop_front());
        d_pops++;
      end
      if (m_acc) begin
        m_lastb = PAD && s_last;
        for (int k = 0; k < W; k++) begin
          if (m_lastb && !s_keep[k]) m_cur.push_back(FP16_NEG_INF);
          else begin
            m_cur.push_back(s_data[k*16 +: 16]);
            m_real++;
          end
        end
        m_beats++;
        if (m_beats == NB || m_lastb) begin
          while (m_cur.size() < N) m_cur.push_back(FP16_NEG_INF);
          for (int i = 0; i < N; i++) m_r.data[i*16 +: 16] = m_cur[i];
          m_r.len = PAD ? m_real : N;
          m_q.push_back(m_r);
          m_cur.delete();
          m_real  = 0;
          m_beats = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("s_ready", 32'(s_ready), 32'(m_q.size() < 2));
    chk("vec_valid", 32'(vec_valid), 32'(m_q.size() > 0));
    if (vec_valid && m_q.size() > 0) begin
      chk_vec("vec_out", vec_out, m_q[0].data);
      chk("vec_len", 32'(vec_len), 32'(m_q[0].len));
    end
  end

  function automatic logic [15:0] fp16_int(input int v);
    int e;
    if (v == 0) return 16'h0000;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return 16'(((e + 15) << 10) | ((v << (10 - e)) & 32'h3FF));
  endfunction

  function automatic logic [W*16-1:0] pat_beat(input int base, input int b);
    logic [W*16-1:0] d;
    for (int k = 0; k < W; k++) d[k*16 +: 16] = fp16_int(base + b * W + k);
    return d;
  endfunction

  function automatic logic [N*16-1:0] exp_row(input int base, input int len);
    logic [N*16-1:0] r;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = (i < len) ? fp16_int(base + i) : FP16_NEG_INF;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [W*16-1:0] d, input logic [W-1:0] k, input logic l);
    bit acc;
    int t;
    t = 0;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    forever begin
      acc = s_ready;
      cycle();
      if (acc) break;
      t++;
      if (t > 200) begin
        fail_timeout("send_beat");
        break;
      end
    end
  endtask

  task automatic send_row_pat(input int base, input int nbeats, input int last_at, input logic [W-1:0] keep);
    for (int b = 0; b < nbeats; b++)
      send_beat(pat_beat(base, b), (b == last_at - 1) ? keep : W'($urandom), b == last_at - 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    s_valid = 1'b0;
    vec_ready = 1'b1;
    while (vec_valid) begin
      cycle();
      t++;
      if (t > 50) begin
        fail_timeout(name);
        break;
      end
    end
  endtask

  typedef struct {
    int         nbeats;
    int         last_at;
    logic [3:0] keep;
    int         exp_len;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int acc_n, cyc, p0;
    logic [N*16-1:0] snap;
    bit a;

`ifdef SOFTMAX_PACK_PAD_EN
    tbl[0] = '{16, 16, 4'b1111, 64};
    tbl[1] = '{3,  3,  4'b0011, 10};
    tbl[2] = '{1,  1,  4'b0000, 0};
    tbl[3] = '{16, 16, 4'b0001, 61};
    tbl[4] = '{5,  5,  4'b1111, 20};
`else
    tbl[0] = '{16, 16, 4'b1111, 64};
    tbl[1] = '{16, 3,  4'b0000, 64};
    tbl[2] = '{16, 1,  4'b0011, 64};
    tbl[3] = '{16, 16, 4'b0001, 64};
    tbl[4] = '{16, 5,  4'b0000, 64};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vec_valid", 32'(vec_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vec_valid", 32'(vec_valid), 32'd0);
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Table-driven single rows, one-cycle latency after the closing beat
    for (int e = 0; e < 5; e++) begin
      vec_ready = 1'b1;
      send_row_pat(0, tbl[e].nbeats, tbl[e].last_at, tbl[e].keep);
      chk("tbl_latency_valid", 32'(vec_valid), 32'd1);
      chk("tbl_len", 32'(vec_len), 32'(tbl[e].exp_len));
      chk_vec("tbl_lanes", vec_out, exp_row(0, tbl[e].exp_len));
      cycle();
      chk("tbl_popped", 32'(vec_valid), 32'd0);
    end

    // Backpressure: 40 beats offered with vec_ready low
    vec_ready = 1'b0;
    acc_n = 0;
    snap = '0;
    s_valid = 1'b1; s_last = 1'b0; s_data = {$urandom, $urandom}; s_keep = W'($urandom);
    for (int c = 0; c < 50; c++) begin
      a = s_ready && s_valid;
      cycle();
      if (a) begin
        acc_n++;
        s_data = {$urandom, $urandom};
        if (acc_n == 16) snap = vec_out;
        if (acc_n == 40) s_valid = 1'b0;
      end
    end
    chk("bp_accepted", 32'(acc_n), 32'd32);
    chk("bp_s_ready_low", 32'(s_ready), 32'd0);
    chk_vec("bp_stable", vec_out, snap);
    p0 = d_pops;
    vec_ready = 1'b1;
    cyc = 0;
    while (acc_n < 40 && cyc < 100) begin
      a = s_ready && s_valid;
      cycle();
      cyc++;
      if (a) begin
        acc_n++;
        s_data = {$urandom, $urandom};
        if (acc_n == 40) s_valid = 1'b0;
      end
    end
    if (acc_n < 40) fail_timeout("bp_resume");
    s_valid = 1'b0;
    for (int b = 0; b < 8; b++) send_beat({$urandom, $urandom}, W'($urandom), 1'b0);
    drain("bp_drain");
    chk("bp_pops", 32'(d_pops - p0), 32'd3);

    // Streaming: four rows at one beat per cycle
    p0 = d_pops;
    acc_n = 0;
    cyc = 0;
    vec_ready = 1'b1;
    s_valid = 1'b1; s_last = 1'b0;
    while (acc_n < 64 && cyc < 100) begin
      chk("stream_s_ready", 32'(s_ready), 32'd1);
      s_data = {$urandom, $urandom};
      a = s_ready;
      cycle();
      cyc++;
      if (a) acc_n++;
    end
    s_valid = 1'b0;
    chk("stream_cycles", 32'(cyc), 32'd64);
    drain("stream_drain");
    chk("stream_pops", 32'(d_pops - p0), 32'd4);

    // Reset mid-row
    for (int b = 0; b < 5; b++) send_beat({$urandom, $urandom}, W'($urandom), 1'b0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vec_valid", 32'(vec_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_after_valid", 32'(vec_valid), 32'd0);
    chk("midrst_after_ready", 32'(s_ready), 32'd1);
    send_row_pat(0, 16, 16, 4'hF);
    chk("midrst_row_valid", 32'(vec_valid), 32'd1);
    chk_vec("midrst_row_lanes", vec_out, exp_row(0, 64));
    chk("midrst_row_len", 32'(vec_len), 32'd64);
    drain("midrst_drain");

    // Close and pop in the same cycle with one row pending
    vec_ready = 1'b0;
    send_row_pat(100, 16, 16, 4'hF);
    send_row_pat(200, 15, 0, 4'hF);
    chk("simul_pending", 32'(vec_valid), 32'd1);
    p0 = d_pops;
    vec_ready = 1'b1;
    send_beat(pat_beat(200, 15), 4'hF, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    chk("simul_pop_once", 32'(d_pops - p0), 32'd1);
    chk("simul_valid", 32'(vec_valid), 32'd1);
    chk("simul_s_ready", 32'(s_ready), 32'd1);
    chk_vec("simul_next_row", vec_out, exp_row(200, 64));
    cycle();
    chk("simul_drained", 32'(vec_valid), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      s_valid   = ($urandom % 4) != 0;
      vec_ready = ($urandom % 3) != 0;
      s_data    = {$urandom, $urandom};
      s_keep    = W'($urandom);
      s_last    = PAD ? (($urandom % 6) == 0) : 1'($urandom);
      cycle();
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/softmax_in_packer.md
SOFTMAX_IN_PACKER -- requirements
Module: softmax_in_packer

Interface
REQ-001 SHALL have parameter N, default 64: lanes per output vector, equal to softmax N.
REQ-002 SHALL have parameter W, default 4: FP16 lanes per input beat; N mod W = 0 and N/W >= 2 are elaboration-time errors otherwise.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_data  input  W*16  FP16 lanes; lane k at bits [k*16 +: 16].
REQ-006 SHALL have port s_keep  input  W  lane-valid mask, honoured on the s_last beat only.
REQ-007 SHALL have port s_last  input  1  final beat of a row.
REQ-008 SHALL have port s_valid  input  1  beat valid.
REQ-009 SHALL have port s_ready  output  1  beat accepted when s_valid and s_ready are both high.
REQ-010 SHALL have port vec_out  output  N*16  packed row, lane i at bits [i*16 +: 16]; feeds softmax x_in.
REQ-011 SHALL have port vec_len  output  $clog2(N)+1  count of real, non-pad lanes in vec_out.
REQ-012 SHALL have port vec_valid  output  1  vec_out/vec_len valid; feeds softmax x_in_valid.
REQ-013 SHALL have port vec_ready  input  1  row consumed when vec_valid and vec_ready are both high; driven by softmax_ready.

Function
REQ-014 SHALL hold two N-lane row buffers (ping-pong), a write pointer wp, a read pointer rp, an occupancy count cnt (0..2) and a beat index idx (0..N/W-1).
REQ-015 SHALL drive s_ready = (cnt < 2), combinationally from registered state only.
REQ-016 SHALL, on each accepted beat, write s_data to lanes idx*W .. idx*W+W-1 of buffer wp and increment idx.
REQ-017 SHALL close the row when the beat at idx = N/W-1 is accepted, and, with SOFTMAX_PACK_PAD_EN defined, also when s_last is accepted at any idx.
REQ-018 SHALL, on row close: set idx to 0, toggle wp, increment cnt, and latch vec_len for that buffer.
REQ-019 SHALL make every lane of a closed row not written during that row read as 0xFC00 (FP16 -inf), so exp contributes 0 downstream.
REQ-020 SHALL, on an s_last beat (PAD_EN defined), store lanes with s_keep = 0 as 0xFC00; vec_len = idx*W + popcount(s_keep).
REQ-021 SHALL drive vec_valid = (cnt > 0), with vec_out and vec_len taken from buffer rp.
REQ-022 SHALL, on vec_valid and vec_ready: toggle rp and decrement cnt.
REQ-023 SHALL leave cnt unchanged when a row close and a pop occur in the same cycle.
REQ-024 SHALL assert vec_valid on the cycle after the closing beat is accepted when cnt was 0, giving 1-cycle latency.
REQ-025 SHALL keep vec_out and vec_len stable while vec_valid is high and vec_ready is low.
REQ-026 SHALL sustain one beat per cycle when vec_ready is held high: no bubble at row boundaries.
REQ-027 SHALL treat an s_last beat with all s_keep bits 0 as closing the row with the lanes of that beat padded.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear cnt, wp, rp and idx to 0, and all latched vec_len to 0.
REQ-029 SHALL give vec_valid = 0 and s_ready = 1 during reset and on the first cycle after it.
REQ-030 SHALL NOT reset buffer data; a reset mid-row discards the partial row and that row's first beat after reset lands at lane 0.

Configuration
REQ-031 SHALL, with SOFTMAX_PACK_PAD_EN defined, support short rows via s_last/s_keep per REQ-017, REQ-019, REQ-020 and REQ-027.
REQ-032 SHALL, without SOFTMAX_PACK_PAD_EN: ignore s_last and s_keep, close rows only at N/W beats, tie vec_len to N, and omit the pad logic.

Structure
REQ-033 SHALL define FP16_NEG_INF = 16'hFC00 and the fp16_t typedef in the shared softmax package.
REQ-034 SHALL place one row buffer, with its lane write enables and pad fill, in a sub-module softmax_row_buf, instantiated twice.

Verification
REQ-035 SHALL cover full row: N=64, W=4, 16 beats with lane value = index as FP16, vec_ready=1 -> vec_valid on the cycle after beat 16, lanes 0..63 exact, vec_len=64.
REQ-036 SHALL cover short row (PAD_EN): 3 beats, s_last on beat 3 with s_keep=4'b0011 -> vec_len=10, lanes 10..63 = 0xFC00.
REQ-037 SHALL cover backpressure: vec_ready=0, 40 beats offered -> s_ready falls after beat 32, vec_out stable; vec_ready=1 -> rows pop in order, input resumes.
REQ-038 SHALL cover streaming: continuous s_valid and vec_ready for 4 rows -> 64 accepted beats in 64 cycles, 4 pops, cnt never 2.
REQ-039 SHALL cover reset mid-row: rst_n pulsed after beat 5 -> vec_valid=0, s_ready=1; the next 16-beat row emerges intact from lane 0.
REQ-040 SHALL cover simultaneous close and pop at cnt=1 -> cnt stays 1, vec_valid stays 1, next row presented the cycle after.
